// File: rtl/arith_wb_if.sv
// Bundles the arith result bus, the register-file write port, and the forwarding lookup
// used by the arith write-back queue.
interface arith_wb_if;
    logic        res_valid;
    logic        res_wr_f;
    logic [31:0] res_data;
    logic [3:0]  res_rd;
    logic        lsu_wr;
    logic        stall;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        flag_c;
    logic [3:0]  lookup_rd;
    logic        lookup_hit;
    logic [15:0] lookup_data;
    logic        overflow;

    modport master (
        output res_valid, res_wr_f, res_data, res_rd, lsu_wr, lookup_rd,
        input  stall, rf_we, rf_waddr, rf_wdata, flag_c, lookup_hit, lookup_data, overflow
    );

    modport slave (
        input  res_valid, res_wr_f, res_data, res_rd, lsu_wr, lookup_rd,
        output stall, rf_we, rf_waddr, rf_wdata, flag_c, lookup_hit, lookup_data, overflow
    );
endinterface

// File: rtl/arith_wb.sv
// Arith write-back queue: buffers ALU results while the load unit owns the register-file
// write port, retires them in order, tracks the carry flag and serves forwarding lookups.
module arith_wb #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    arith_wb_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [3:0]    q_rd   [DEPTH];
    logic [15:0]   q_data [DEPTH];
    logic          q_wrf  [DEPTH];
    logic          q_c    [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] occ;
    logic          flag_c_r;
    logic          overflow_r;

    logic          full;
    logic          push;
    logic          pop;
    logic          lk_hit;
    logic [15:0]   lk_data;
    logic [PW-1:0] lk_idx;
    logic          unused_res_hi;

    assign unused_res_hi = ^bus.res_data[31:17];

    // Full is taken from registered occupancy, so a pop on the same edge cannot make room.
    assign full = (occ == CW'(DEPTH));
    assign push = bus.res_valid && !full;
    assign pop  = (occ != '0) && !bus.lsu_wr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            flag_c_r   <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (q_wrf[rd_ptr]) begin
                    flag_c_r <= q_c[rd_ptr];
                end
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            if (bus.res_valid && full) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Payload storage carries no reset; validity comes solely from occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= bus.res_rd;
            q_data[wr_ptr] <= bus.res_data[15:0];
            q_wrf[wr_ptr]  <= bus.res_wr_f;
            q_c[wr_ptr]    <= bus.res_data[16];
        end
    end

    // Walk oldest to youngest so the last match, the youngest, wins.
    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        lk_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            lk_idx = rd_ptr + PW'(k);
            if ((CW'(k) < occ) && (q_rd[lk_idx] == bus.lookup_rd)) begin
                lk_hit  = 1'b1;
                lk_data = q_data[lk_idx];
            end
        end
    end

    assign bus.stall       = full;
    assign bus.rf_we       = pop;
    assign bus.rf_waddr    = pop ? q_rd[rd_ptr]   : 4'd0;
    assign bus.rf_wdata    = pop ? q_data[rd_ptr] : 16'd0;
    assign bus.flag_c      = flag_c_r;
    assign bus.overflow    = overflow_r;
    assign bus.lookup_hit  = lk_hit;
    assign bus.lookup_data = lk_data;
endmodule

// File: tb/tb_arith_wb.sv
// Self-checking bench for arith_wb: a queue model scores every write-back, flag and lookup,
// while per-scenario tasks check the directed cases inline.
module tb_arith_wb;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0]  rd;
        logic [15:0] data;
        logic        wrf;
        logic        c;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    ent_t mq[$];
    logic mflag = 1'b0;
    logic movf  = 1'b0;

    arith_wb_if bus ();

    arith_wb #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference queue: updated on the same edges the DUT uses.
    always @(posedge clk) begin : model
        ent_t e;
        logic was_full;
        if (rst) begin
            was_full = (mq.size() == DEPTH);
            if (mq.size() > 0 && !bus.lsu_wr) begin
                e = mq.pop_front();
                if (e.wrf) mflag = e.c;
            end
            if (bus.res_valid) begin
                if (was_full) movf = 1'b1;
                else mq.push_back('{bus.res_rd, bus.res_data[15:0], bus.res_wr_f, bus.res_data[16]});
            end
        end
    end

    always @(negedge rst) begin
        mq.delete();
        mflag = 1'b0;
        movf  = 1'b0;
    end

    // Scoreboard: compares the DUT against the model every cycle.
    always @(negedge clk) begin : monitor
        logic        ep;
        logic        lhit;
        logic [15:0] ldata;
        logic [3:0]  ewa;
        logic [15:0] ewd;
        ep  = (mq.size() > 0) && !bus.lsu_wr;
        ewa = ep ? mq[0].rd : 4'd0;
        ewd = ep ? mq[0].data : 16'd0;
        lhit  = 1'b0;
        ldata = 16'd0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].rd == bus.lookup_rd) begin
                lhit  = 1'b1;
                ldata = mq[i].data;
                break;
            end
        end
        checks += 7;
        if (bus.rf_we !== ep) begin errors++; $display("FAIL sb_rf_we t=%0t got %b want %b", $time, bus.rf_we, ep); end
        if (bus.rf_waddr !== ewa) begin errors++; $display("FAIL sb_waddr t=%0t got %0d want %0d", $time, bus.rf_waddr, ewa); end
        if (bus.rf_wdata !== ewd) begin errors++; $display("FAIL sb_wdata t=%0t got %h want %h", $time, bus.rf_wdata, ewd); end
        if (bus.stall !== (mq.size() == DEPTH)) begin errors++; $display("FAIL sb_stall t=%0t got %b want %b", $time, bus.stall, mq.size() == DEPTH); end
        if (bus.flag_c !== mflag) begin errors++; $display("FAIL sb_flag_c t=%0t got %b want %b", $time, bus.flag_c, mflag); end
        if (bus.overflow !== movf) begin errors++; $display("FAIL sb_overflow t=%0t got %b want %b", $time, bus.overflow, movf); end
        if (bus.lookup_hit !== lhit || bus.lookup_data !== ldata) begin
            errors++;
            $display("FAIL sb_lookup t=%0t got %b/%h want %b/%h", $time, bus.lookup_hit, bus.lookup_data, lhit, ldata);
        end
    end

    task automatic drive(input logic v, input logic [3:0] rd, input logic [31:0] d,
                         input logic wf, input logic lsu);
        @(posedge clk);
        #1;
        bus.res_valid = v;
        bus.res_rd    = rd;
        bus.res_data  = d;
        bus.res_wr_f  = wf;
        bus.lsu_wr    = lsu;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.stall, bus.rf_we, bus.flag_c, bus.overflow, bus.lookup_hit} !== 5'b0) begin
            errors++;
            $display("FAIL reset_state got %b want 00000",
                     {bus.stall, bus.rf_we, bus.flag_c, bus.overflow, bus.lookup_hit});
        end
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_single();
        drive(1'b1, 4'd3, 32'h0001_1234, 1'b1, 1'b0);
        drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 4'd3 || bus.rf_wdata !== 16'h1234) begin
            errors++;
            $display("FAIL single_write got %b/%0d/%h want 1/3/1234", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        @(negedge clk);
        checks++;
        if (bus.rf_we !== 1'b0 || bus.flag_c !== 1'b1) begin
            errors++;
            $display("FAIL single_after got we=%b c=%b want we=0 c=1", bus.rf_we, bus.flag_c);
        end
    endtask

    task automatic test_lookup();
        drive(1'b1, 4'd5, 32'h0000_1111, 1'b0, 1'b1);
        drive(1'b1, 4'd5, 32'h0000_2222, 1'b0, 1'b1);
        drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
        bus.lookup_rd = 4'd5;
        @(negedge clk);
        checks++;
        if (bus.lookup_hit !== 1'b1 || bus.lookup_data !== 16'h2222) begin
            errors++;
            $display("FAIL lookup_youngest got %b/%h want 1/2222", bus.lookup_hit, bus.lookup_data);
        end
        drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
        bus.lookup_rd = 4'd6;
        @(negedge clk);
        checks++;
        if (bus.lookup_hit !== 1'b0 || bus.lookup_data !== 16'h0) begin
            errors++;
            $display("FAIL lookup_miss got %b/%h want 0/0000", bus.lookup_hit, bus.lookup_data);
        end
        repeat (4) drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_flags();
        drive(1'b1, 4'd1, 32'h0001_0000, 1'b1, 1'b0);
        repeat (3) drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.flag_c !== 1'b1) begin errors++; $display("FAIL flag_set got %b want 1", bus.flag_c); end
        drive(1'b1, 4'd2, 32'h0001_0005, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.flag_c !== 1'b1) begin errors++; $display("FAIL flag_hold got %b want 1", bus.flag_c); end
        drive(1'b1, 4'd4, 32'h0000_FFFF, 1'b1, 1'b0);
        repeat (3) drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.flag_c !== 1'b0) begin errors++; $display("FAIL flag_clear got %b want 0", bus.flag_c); end
    endtask

    task automatic test_back_to_back();
        int wcount = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 4'(i), 32'h0000_A000 + 32'(i), 1'(i % 2), 1'b0);
            @(negedge clk);
            if (bus.rf_we) wcount++;
            checks++;
            if (bus.stall !== 1'b0 || (i > 0 && bus.rf_we !== 1'b1)) begin
                errors++;
                $display("FAIL stream_cycle%0d got stall=%b we=%b want stall=0 we=%b", i, bus.stall, bus.rf_we, i > 0);
            end
        end
        repeat (2) begin
            drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
            @(negedge clk);
            if (bus.rf_we) wcount++;
        end
        checks++;
        if (wcount != 20 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL stream_total got %0d writes ovf=%b want 20 ovf=0", wcount, bus.overflow);
        end
    endtask

    task automatic test_fill();
        logic [3:0] seen[$];
        for (int i = 0; i < 6; i++) drive(1'b1, 4'(8 + i), 32'h0001_B000 + 32'(i), 1'b1, 1'b1);
        drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b1 || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL fill_full got stall=%b ovf=%b want 1/1", bus.stall, bus.overflow);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
            @(negedge clk);
            if (bus.rf_we) seen.push_back(bus.rf_waddr);
        end
        checks++;
        if (seen.size() != 4) begin
            errors++;
            $display("FAIL fill_count got %0d writes want 4", seen.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (seen[i] !== 4'(8 + i)) begin
                    errors++;
                    $display("FAIL fill_order%0d got %0d want %0d", i, seen[i], 8 + i);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 4'd7, 32'h0001_1111, 1'b1, 1'b0);
        repeat (2) drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 4'd12, 32'h0000_C000 + 32'(i), 1'b1, 1'b1);
        drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
        bus.lookup_rd = 4'd12;
        #2;
        bus.lsu_wr = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.stall, bus.rf_we, bus.flag_c, bus.overflow, bus.lookup_hit} !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid got %b want 00000",
                     {bus.stall, bus.rf_we, bus.flag_c, bus.overflow, bus.lookup_hit});
        end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if (bus.rf_we !== 1'b0) begin
                errors++;
                $display("FAIL reset_release%0d got we=%b want 0", i, bus.rf_we);
            end
        end
    endtask

    initial begin
        bus.res_valid = 1'b0;
        bus.res_wr_f  = 1'b0;
        bus.res_data  = 32'h0;
        bus.res_rd    = 4'd0;
        bus.lsu_wr    = 1'b0;
        bus.lookup_rd = 4'd15;
        test_reset();
        test_single();
        test_lookup();
        test_flags();
        test_back_to_back();
        test_fill();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
